dest_reg_hazard_unit: RTL and testbench

- Consumer of the muxed destination-register field (rt/rd selected by RegDst) in the 5-stage MIPS pipeline.
- Tracks that destination, with RegWrite/MemRead, through internal EX/MEM and MEM/WB stage registers.
- Produces ALU operand forwarding selects for the EX stage and the load-use stall for IF/ID.
- Maintains a saturating stall counter for performance debug.

---
 rtl/dest_reg_hazard_unit.sv | 105 ++++++++++
 tb/tb_dest_reg_hazard_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/dest_reg_hazard_unit.sv
// Destination-register tracker for the 5-stage pipeline: EX/MEM and MEM/WB
// copies of the muxed dest drive ALU forwarding, the load-use stall and a stall counter.
module dest_reg_hazard_unit #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       ex_dest,
   input  logic             ex_reg_write,
   input  logic             ex_mem_read,
   input  logic             ex_valid,
   input  logic [4:0]       ex_rs,
   input  logic [4:0]       ex_rt,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rt,
   input  logic             flush,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic             stall,
   output logic [4:0]       mem_dest,
   output logic             mem_reg_write,
   output logic [4:0]       wb_dest,
   output logic             wb_reg_write,
   output logic [CNT_W-1:0] stall_count
);

   logic [4:0]       mem_dest_q, mem_dest_d;
   logic             mem_rw_q, mem_rw_d;
   logic             mem_mr_q, mem_mr_d;
   logic [4:0]       wb_dest_q, wb_dest_d;
   logic             wb_rw_q, wb_rw_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ex_live;
   logic             mem_hit_ok;
   logic             wb_hit_ok;

   // Squashed or bubble instructions travel down with their write/load bits cleared.
   assign ex_live = ex_valid & ~flush;

   always_comb begin
      mem_dest_d = ex_dest;
      mem_rw_d   = ex_reg_write & ex_live;
      mem_mr_d   = ex_mem_read & ex_live;
      wb_dest_d  = mem_dest_q;
      wb_rw_d    = mem_rw_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mem_dest_q <= '0;
         mem_rw_q   <= 1'b0;
         mem_mr_q   <= 1'b0;
         wb_dest_q  <= '0;
         wb_rw_q    <= 1'b0;
         cnt_q      <= '0;
      end else begin
         mem_dest_q <= mem_dest_d;
         mem_rw_q   <= mem_rw_d;
         mem_mr_q   <= mem_mr_d;
         wb_dest_q  <= wb_dest_d;
         wb_rw_q    <= wb_rw_d;
         cnt_q      <= cnt_d;
      end
   end

   assign mem_hit_ok = mem_rw_q & (mem_dest_q != 5'd0) & ~mem_mr_q;
   assign wb_hit_ok  = wb_rw_q & (wb_dest_q != 5'd0);

   // EX/MEM is checked first so the newest producer wins.
   always_comb begin
      fwd_a = 2'b00;
      if (mem_hit_ok && mem_dest_q == ex_rs)
         fwd_a = 2'b10;
      else if (wb_hit_ok && wb_dest_q == ex_rs)
         fwd_a = 2'b01;
   end

   always_comb begin
      fwd_b = 2'b00;
      if (mem_hit_ok && mem_dest_q == ex_rt)
         fwd_b = 2'b10;
      else if (wb_hit_ok && wb_dest_q == ex_rt)
         fwd_b = 2'b01;
   end

   always_comb begin
      stall = 1'b0;
      if (ex_valid && ex_mem_read && !flush && ex_dest != 5'd0)
         stall = (ex_dest == id_rs) | (id_uses_rt & (ex_dest == id_rt));
   end

   always_comb begin
      cnt_d = cnt_q;
      if (stall && cnt_q != {CNT_W{1'b1}})
         cnt_d = cnt_q + 1'b1;
   end

   assign mem_dest      = mem_dest_q;
   assign mem_reg_write = mem_rw_q;
   assign wb_dest       = wb_dest_q;
   assign wb_reg_write  = wb_rw_q;
   assign stall_count   = cnt_q;

endmodule

// File: tb/tb_dest_reg_hazard_unit.sv
// Directed bench for dest_reg_hazard_unit: forwarding priority, load-use stall,
// flush/bubble/$0 squashing and stall counter saturation with CNT_W=4.
module tb_dest_reg_hazard_unit;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] ex_dest;
   logic       ex_reg_write;
   logic       ex_mem_read;
   logic       ex_valid;
   logic [4:0] ex_rs;
   logic [4:0] ex_rt;
   logic [4:0] id_rs;
   logic [4:0] id_rt;
   logic       id_uses_rt;
   logic       flush;
   logic [1:0] fwd_a;
   logic [1:0] fwd_b;
   logic       stall;
   logic [4:0] mem_dest;
   logic       mem_reg_write;
   logic [4:0] wb_dest;
   logic       wb_reg_write;
   logic [3:0] stall_count;

   int checks = 0;
   int errors = 0;

   dest_reg_hazard_unit #(.CNT_W(4)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .ex_dest(ex_dest),
      .ex_reg_write(ex_reg_write),
      .ex_mem_read(ex_mem_read),
      .ex_valid(ex_valid),
      .ex_rs(ex_rs),
      .ex_rt(ex_rt),
      .id_rs(id_rs),
      .id_rt(id_rt),
      .id_uses_rt(id_uses_rt),
      .flush(flush),
      .fwd_a(fwd_a),
      .fwd_b(fwd_b),
      .stall(stall),
      .mem_dest(mem_dest),
      .mem_reg_write(mem_reg_write),
      .wb_dest(wb_dest),
      .wb_reg_write(wb_reg_write),
      .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic ex(input logic [4:0] d, input logic rw,
                     input logic mr, input logic v);
      ex_dest      = d;
      ex_reg_write = rw;
      ex_mem_read  = mr;
      ex_valid     = v;
   endtask

   initial begin
      rst_n = 1'b0;
      ex(5'd5, 1'b1, 1'b0, 1'b1);
      ex_rs = 5'd5;
      ex_rt = 5'd5;
      id_rs = 5'd0;
      id_rt = 5'd0;
      id_uses_rt = 1'b0;
      flush = 1'b0;
      nxt();
      nxt();
      #1;
      chk("rst_mem_dest", 32'(mem_dest), 32'd0);
      chk("rst_wb_dest", 32'(wb_dest), 32'd0);
      chk("rst_mem_rw", 32'(mem_reg_write), 32'd0);
      chk("rst_wb_rw", 32'(wb_reg_write), 32'd0);
      chk("rst_count", 32'(stall_count), 32'd0);
      chk("rst_fwd_a", 32'(fwd_a), 32'd0);
      chk("rst_fwd_b", 32'(fwd_b), 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);

      // C0: producer of $8
      rst_n = 1'b1;
      ex(5'd8, 1'b1, 1'b0, 1'b1);
      ex_rs = 5'd0;
      ex_rt = 5'd0;
      nxt();
      // C1: consumer back-to-back
      ex(5'd3, 1'b0, 1'b0, 1'b1);
      ex_rs = 5'd8;
      ex_rt = 5'd8;
      #1;
      chk("b2b_mem_dest", 32'(mem_dest), 32'd8);
      chk("b2b_mem_rw", 32'(mem_reg_write), 32'd1);
      chk("b2b_fwd_a", 32'(fwd_a), 32'd2);
      chk("b2b_fwd_b", 32'(fwd_b), 32'd2);
      nxt();
      // C2: $8 now in MEM/WB
      ex(5'd9, 1'b1, 1'b0, 1'b1);
      ex_rs = 5'd8;
      ex_rt = 5'd0;
      #1;
      chk("wb_dest_lat2", 32'(wb_dest), 32'd8);
      chk("wb_fwd_a", 32'(fwd_a), 32'd1);
      chk("wb_fwd_b", 32'(fwd_b), 32'd0);
      nxt();
      // C3: second producer of $9
      ex_rs = 5'd0;
      nxt();
      // C4: both stages hold $9
      ex(5'd0, 1'b1, 1'b0, 1'b1);
      ex_rs = 5'd9;
      ex_rt = 5'd9;
      #1;
      chk("dbl_wb_dest", 32'(wb_dest), 32'd9);
      chk("dbl_fwd_a", 32'(fwd_a), 32'd2);
      chk("dbl_fwd_b", 32'(fwd_b), 32'd2);
      nxt();
      // C5: $0 writes start filling the tracker
      ex_rs = 5'd0;
      ex_rt = 5'd0;
      nxt();
      // C6: both entries dest 0 with reg_write
      #1;
      chk("zero_mem_dest", 32'(mem_dest), 32'd0);
      chk("zero_wb_rw", 32'(wb_reg_write), 32'd1);
      chk("zero_fwd_a", 32'(fwd_a), 32'd0);
      chk("zero_fwd_b", 32'(fwd_b), 32'd0);
      nxt();
      // C7: load-use on $10
      ex(5'd10, 1'b1, 1'b1, 1'b1);
      id_rs = 5'd10;
      #1;
      chk("lu_stall", 32'(stall), 32'd1);
      chk("lu_count_before", 32'(stall_count), 32'd0);
      nxt();
      // C8: bubble injected
      ex(5'd0, 1'b0, 1'b0, 1'b0);
      #1;
      chk("lu_stall_once", 32'(stall), 32'd0);
      chk("lu_count", 32'(stall_count), 32'd1);
      nxt();
      // C9: dependent instruction in EX
      ex(5'd13, 1'b1, 1'b0, 1'b1);
      ex_rs = 5'd10;
      id_rs = 5'd0;
      #1;
      chk("lu_fwd_a", 32'(fwd_a), 32'd1);
      chk("lu_dep_stall", 32'(stall), 32'd0);
      nxt();
      // C10: rt hazard gated by id_uses_rt
      ex(5'd11, 1'b1, 1'b1, 1'b1);
      ex_rs = 5'd0;
      id_rt = 5'd11;
      id_uses_rt = 1'b0;
      #1;
      chk("rt_unused_stall", 32'(stall), 32'd0);
      id_uses_rt = 1'b1;
      #1;
      chk("rt_used_stall", 32'(stall), 32'd1);
      nxt();
      // C11: flushed load
      ex(5'd12, 1'b1, 1'b1, 1'b1);
      flush = 1'b1;
      id_rs = 5'd12;
      id_rt = 5'd0;
      id_uses_rt = 1'b0;
      #1;
      chk("flush_stall", 32'(stall), 32'd0);
      chk("flush_count", 32'(stall_count), 32'd2);
      nxt();
      // C12: squashed load sits in EX/MEM
      flush = 1'b0;
      ex(5'd0, 1'b0, 1'b0, 1'b0);
      ex_rs = 5'd12;
      id_rs = 5'd0;
      #1;
      chk("flush_mem_dest", 32'(mem_dest), 32'd12);
      chk("flush_mem_rw", 32'(mem_reg_write), 32'd0);
      chk("flush_fwd_a", 32'(fwd_a), 32'd0);
      chk("flush_wb_dest", 32'(wb_dest), 32'd11);
      nxt();
      // C13: $0 load and invalid load never stall
      ex(5'd0, 1'b1, 1'b1, 1'b1);
      ex_rs = 5'd0;
      id_rs = 5'd0;
      #1;
      chk("zero_load_stall", 32'(stall), 32'd0);
      ex(5'd14, 1'b1, 1'b1, 1'b0);
      id_rs = 5'd14;
      #1;
      chk("bubble_load_stall", 32'(stall), 32'd0);
      nxt();
      chk("no_stall_count", 32'(stall_count), 32'd2);
      // Saturation: hold the stall condition for 20 cycles
      ex(5'd10, 1'b1, 1'b1, 1'b1);
      id_rs = 5'd10;
      for (int k = 1; k <= 20; k++) begin
         nxt();
         chk($sformatf("sat_count_%0d", k), 32'(stall_count),
             (2 + k > 15) ? 32'd15 : 32'(2 + k));
      end
      ex(5'd0, 1'b0, 1'b0, 1'b0);
      nxt();
      chk("sat_hold", 32'(stall_count), 32'd15);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
